// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and state type for the programmable clock divider
package clk_div_pkg;

   localparam int CLK_DIV_MIN       = 2;
   localparam int CLK_DIV_WIDTH_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } clk_div_state_e;

endpackage

// File: rtl/clk_div_cnt.sv
// rtl/clk_div_cnt.sv - period counter and high-phase compare for the divider
module clk_div_cnt
   import clk_div_pkg::*;
#(
   parameter int DIV_WIDTH = CLK_DIV_WIDTH_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [DIV_WIDTH-1:0] i_div,
   input  logic [DIV_WIDTH-1:0] i_div_nxt,
   input  logic                 i_start,
   input  logic                 i_run,
   output logic                 o_period_end,
   output logic                 o_clk_nxt,
   output logic                 o_clk_en_nxt
);

   logic [DIV_WIDTH-1:0] r_k;
   logic [DIV_WIDTH-1:0] w_k_nxt;
   logic [DIV_WIDTH:0]   w_high_len;

   always_comb begin
      w_k_nxt = '0;
      if (i_start) begin
         w_k_nxt = '0;
      end else if (i_run) begin
         w_k_nxt = r_k + 1'b1;
      end
   end

   // High phase is ceil(N/2) cycles, evaluated against the ratio the next cycle runs with.
   assign w_high_len   = ({1'b0, i_div_nxt} + 1'b1) >> 1;
   assign o_period_end = (r_k == (i_div - 1'b1));
   assign o_clk_nxt    = (i_start | i_run) & ({1'b0, w_k_nxt} < w_high_len);
   assign o_clk_en_nxt = i_start;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_k <= '0;
      end else begin
         r_k <= w_k_nxt;
      end
   end

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - programmable integer clock divider with boundary-aligned ratio updates
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int DIV_WIDTH   = CLK_DIV_WIDTH_DEF,
   parameter int DEFAULT_DIV = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic                 div_valid_i,
   output logic                 div_ready_o,
   output logic [DIV_WIDTH-1:0] div_o,
   output logic                 running_o,
   output logic                 clk_en_o,
   output logic                 clk_o
);

   localparam logic [DIV_WIDTH-1:0] L_DIV_MIN = DIV_WIDTH'(CLK_DIV_MIN);
   localparam logic [DIV_WIDTH-1:0] L_DIV_RST = DIV_WIDTH'(DEFAULT_DIV);

   clk_div_state_e       r_state;
   clk_div_state_e       w_state_nxt;
   logic [DIV_WIDTH-1:0] r_div;
   logic [DIV_WIDTH-1:0] r_pend;
   logic                 r_pend_vld;
   logic                 r_ready;
   logic                 r_running;
   logic                 r_clk;
   logic                 r_clk_en;

   logic [DIV_WIDTH-1:0] w_div_nxt;
   logic [DIV_WIDTH-1:0] w_div_clamped;
   logic                 w_accept;
   logic                 w_load;
   logic                 w_start;
   logic                 w_run;
   logic                 w_period_end;
   logic                 w_clk_nxt;
   logic                 w_clk_en_nxt;

   assign w_accept      = div_valid_i & r_ready;
   assign w_div_clamped = (div_i < L_DIV_MIN) ? L_DIV_MIN : div_i;

   // The pending ratio only moves to active from the register, so a capture on the last cycle waits a full period.
   assign w_load    = r_pend_vld & ((r_state == IDLE) | ((r_state == RUN) & w_period_end));
   assign w_div_nxt = w_load ? r_pend : r_div;

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_run       = 1'b0;
      case (r_state)
         IDLE: begin
            if (en_i) begin
               w_start     = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_period_end) begin
               if (en_i) begin
                  w_start = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else begin
               w_run = 1'b1;
            end
         end
      endcase
   end

   clk_div_cnt #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_cnt (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .i_div        (r_div),
      .i_div_nxt    (w_div_nxt),
      .i_start      (w_start),
      .i_run        (w_run),
      .o_period_end (w_period_end),
      .o_clk_nxt    (w_clk_nxt),
      .o_clk_en_nxt (w_clk_en_nxt)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= IDLE;
         r_div     <= L_DIV_RST;
         r_running <= 1'b0;
         r_clk     <= 1'b0;
         r_clk_en  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_div     <= w_div_nxt;
         r_running <= (w_state_nxt == RUN);
         r_clk     <= w_clk_nxt;
         r_clk_en  <= w_clk_en_nxt;
      end
   end

   // Accept and load are exclusive: ready is only high while nothing is pending.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pend     <= '0;
         r_pend_vld <= 1'b0;
         r_ready    <= 1'b1;
      end else if (w_accept) begin
         r_pend     <= w_div_clamped;
         r_pend_vld <= 1'b1;
         r_ready    <= 1'b0;
      end else if (w_load) begin
         r_pend_vld <= 1'b0;
         r_ready    <= 1'b1;
      end
   end

   assign div_ready_o = r_ready;
   assign div_o       = r_div;
   assign running_o   = r_running;
   assign clk_en_o    = r_clk_en;
   assign clk_o       = r_clk;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
module tb_clk_div_prog;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       en_i = 1'b0;
   logic [7:0] div_i = 8'd0;
   logic       div_valid_i = 1'b0;
   logic       div_ready_o;
   logic [7:0] div_o;
   logic       running_o;
   logic       clk_en_o;
   logic       clk_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk_i = ~clk_i;

   clk_div_prog #(
      .DIV_WIDTH   (8),
      .DEFAULT_DIV (2)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .div_i       (div_i),
      .div_valid_i (div_valid_i),
      .div_ready_o (div_ready_o),
      .div_o       (div_o),
      .running_o   (running_o),
      .clk_en_o    (clk_en_o),
      .clk_o       (clk_o)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic go_idle();
      en_i = 1'b0;
      for (int i = 0; i < 20 && running_o; i++) step();
      n_tests++;
      if (running_o !== 1'b0) begin
         n_fail++;
         $display("FAIL go_idle running_o=%b expected 0 within 20 cycles", running_o);
      end
   endtask

   task automatic set_div_idle(input logic [7:0] v, input logic [7:0] exp);
      div_i = v;
      div_valid_i = 1'b1;
      step();
      div_valid_i = 1'b0;
      n_tests++;
      if (div_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL set_div_ready_drop div_i=%0d ready=%b expected 0", v, div_ready_o);
      end
      step();
      n_tests++;
      if (div_o !== exp || div_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL set_div_active div_i=%0d div_o=%0d ready=%b expected div_o=%0d ready=1", v, div_o, div_ready_o, exp);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      en_i = 1'b0;
      div_valid_i = 1'b0;
      step();
      rst_i = 1'b0;
      n_tests++;
      if (clk_o !== 1'b0) begin n_fail++; $display("FAIL reset_clk_o got %b expected 0", clk_o); end
      n_tests++;
      if (clk_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_clk_en_o got %b expected 0", clk_en_o); end
      n_tests++;
      if (running_o !== 1'b0) begin n_fail++; $display("FAIL reset_running_o got %b expected 0", running_o); end
      n_tests++;
      if (div_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_div_ready_o got %b expected 1", div_ready_o); end
      n_tests++;
      if (div_o !== 8'd2) begin n_fail++; $display("FAIL reset_div_o got %0d expected 2", div_o); end
   endtask

   task automatic test_div2();
      en_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_tests++;
         if (clk_o !== (i % 2 == 0) || clk_en_o !== (i % 2 == 0) || running_o !== 1'b1) begin
            n_fail++;
            $display("FAIL div2 cyc=%0d clk_o=%b clk_en_o=%b running=%b expected %b %b 1",
                     i, clk_o, clk_en_o, running_o, (i % 2 == 0), (i % 2 == 0));
         end
      end
   endtask

   task automatic test_ratio5();
      go_idle();
      set_div_idle(8'd5, 8'd5);
      en_i = 1'b1;
      for (int i = 0; i < 15; i++) begin
         step();
         n_tests++;
         if (clk_o !== ((i % 5) < 3) || clk_en_o !== ((i % 5) == 0) || div_o !== 8'd5) begin
            n_fail++;
            $display("FAIL ratio5 k=%0d clk_o=%b clk_en_o=%b div_o=%0d expected %b %b 5",
                     i % 5, clk_o, clk_en_o, div_o, ((i % 5) < 3), ((i % 5) == 0));
         end
      end
   endtask

   task automatic test_change_mid();
      go_idle();
      set_div_idle(8'd4, 8'd4);
      en_i = 1'b1;
      step();
      step();
      div_i = 8'd6;
      div_valid_i = 1'b1;
      step();
      n_tests++;
      if (div_ready_o !== 1'b0 || div_o !== 8'd4 || clk_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_accept ready=%b div_o=%0d clk_o=%b expected 0 4 0", div_ready_o, div_o, clk_o);
      end
      div_i = 8'd3;
      step();
      div_valid_i = 1'b0;
      n_tests++;
      if (div_ready_o !== 1'b0 || clk_o !== 1'b0 || clk_en_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_k3 ready=%b clk_o=%b clk_en_o=%b expected 0 0 0", div_ready_o, clk_o, clk_en_o);
      end
      step();
      n_tests++;
      if (clk_en_o !== 1'b1 || clk_o !== 1'b1 || div_o !== 8'd6 || div_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_switch clk_en_o=%b clk_o=%b div_o=%0d ready=%b expected 1 1 6 1",
                  clk_en_o, clk_o, div_o, div_ready_o);
      end
      for (int k = 1; k < 6; k++) begin
         step();
         n_tests++;
         if (clk_o !== (k < 3) || clk_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_n6 k=%0d clk_o=%b clk_en_o=%b expected %b 0", k, clk_o, clk_en_o, (k < 3));
         end
      end
      step();
      n_tests++;
      if (clk_en_o !== 1'b1 || div_o !== 8'd6) begin
         n_fail++;
         $display("FAIL mid_no_queue clk_en_o=%b div_o=%0d expected 1 6", clk_en_o, div_o);
      end
   endtask

   task automatic test_change_last();
      go_idle();
      set_div_idle(8'd4, 8'd4);
      en_i = 1'b1;
      for (int i = 0; i < 4; i++) step();
      div_i = 8'd3;
      div_valid_i = 1'b1;
      step();
      div_valid_i = 1'b0;
      n_tests++;
      if (clk_en_o !== 1'b1 || div_o !== 8'd4 || div_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL last_hold clk_en_o=%b div_o=%0d ready=%b expected 1 4 0", clk_en_o, div_o, div_ready_o);
      end
      for (int k = 1; k < 4; k++) begin
         step();
         n_tests++;
         if (clk_o !== (k < 2) || clk_en_o !== 1'b0) begin
            n_fail++;
            $display("FAIL last_n4 k=%0d clk_o=%b clk_en_o=%b expected %b 0", k, clk_o, clk_en_o, (k < 2));
         end
      end
      step();
      n_tests++;
      if (clk_en_o !== 1'b1 || div_o !== 8'd3 || div_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL last_switch clk_en_o=%b div_o=%0d ready=%b expected 1 3 1", clk_en_o, div_o, div_ready_o);
      end
      for (int j = 1; j < 7; j++) begin
         step();
         n_tests++;
         if (clk_o !== ((j % 3) < 2) || clk_en_o !== ((j % 3) == 0)) begin
            n_fail++;
            $display("FAIL last_n3 k=%0d clk_o=%b clk_en_o=%b expected %b %b",
                     j % 3, clk_o, clk_en_o, ((j % 3) < 2), ((j % 3) == 0));
         end
      end
   endtask

   task automatic test_clamp();
      go_idle();
      set_div_idle(8'd0, 8'd2);
      set_div_idle(8'd7, 8'd7);
      set_div_idle(8'd1, 8'd2);
   endtask

   task automatic test_stop();
      set_div_idle(8'd6, 8'd6);
      en_i = 1'b1;
      step();
      step();
      en_i = 1'b0;
      for (int k = 2; k < 6; k++) begin
         step();
         n_tests++;
         if (clk_o !== (k < 3) || running_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_tail k=%0d clk_o=%b running=%b expected %b 1", k, clk_o, running_o, (k < 3));
         end
      end
      step();
      n_tests++;
      if (running_o !== 1'b0 || clk_o !== 1'b0 || clk_en_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_idle running=%b clk_o=%b clk_en_o=%b expected 0 0 0", running_o, clk_o, clk_en_o);
      end
      step();
      step();
      n_tests++;
      if (running_o !== 1'b0 || clk_o !== 1'b0) begin
         n_fail++;
         $display("FAIL stop_hold running=%b clk_o=%b expected 0 0", running_o, clk_o);
      end
   endtask

   task automatic test_reassert();
      en_i = 1'b1;
      step();
      step();
      en_i = 1'b0;
      step();
      step();
      step();
      en_i = 1'b1;
      step();
      n_tests++;
      if (clk_o !== 1'b0 || running_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reassert_k5 clk_o=%b running=%b expected 0 1", clk_o, running_o);
      end
      step();
      n_tests++;
      if (clk_en_o !== 1'b1 || clk_o !== 1'b1 || running_o !== 1'b1) begin
         n_fail++;
         $display("FAIL reassert_nogap clk_en_o=%b clk_o=%b running=%b expected 1 1 1", clk_en_o, clk_o, running_o);
      end
   endtask

   task automatic test_reset_pending();
      go_idle();
      set_div_idle(8'd8, 8'd8);
      en_i = 1'b1;
      step();
      step();
      div_i = 8'd5;
      div_valid_i = 1'b1;
      step();
      div_valid_i = 1'b0;
      n_tests++;
      if (div_ready_o !== 1'b0 || div_o !== 8'd8) begin
         n_fail++;
         $display("FAIL rstp_pending ready=%b div_o=%0d expected 0 8", div_ready_o, div_o);
      end
      rst_i = 1'b1;
      en_i = 1'b0;
      step();
      rst_i = 1'b0;
      n_tests++;
      if (div_o !== 8'd2 || div_ready_o !== 1'b1 || running_o !== 1'b0 || clk_o !== 1'b0 || clk_en_o !== 1'b0) begin
         n_fail++;
         $display("FAIL rstp_values div_o=%0d ready=%b running=%b clk_o=%b clk_en_o=%b expected 2 1 0 0 0",
                  div_o, div_ready_o, running_o, clk_o, clk_en_o);
      end
      step();
      step();
      n_tests++;
      if (div_o !== 8'd2 || div_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rstp_lost div_o=%0d ready=%b expected 2 1", div_o, div_ready_o);
      end
      en_i = 1'b1;
      step();
      n_tests++;
      if (clk_o !== 1'b1 || clk_en_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rstp_restart clk_o=%b clk_en_o=%b expected 1 1", clk_o, clk_en_o);
      end
      step();
      step();
      n_tests++;
      if (clk_en_o !== 1'b1 || clk_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rstp_n2 clk_en_o=%b clk_o=%b expected 1 1", clk_en_o, clk_o);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_div2();
      test_ratio5();
      test_change_mid();
      test_change_last();
      test_clamp();
      test_stop();
      test_reassert();
      test_reset_pending();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
